// File: rtl/camera_frame_capture.sv
// -----------------------------------------------------------------------------
// camera_frame_capture
//
// Capture front end between the camera pins and the frame RAM write port.
// Generates the camera master clock, oversamples PCLK/VSYNC/HREF/D into the
// Clk domain, and crops plus decimates one armed frame to FRAME_W x FRAME_H
// luma bytes.  The kept bytes are written to sequential RAM addresses
// starting at 0, after which a one-cycle frame-done pulse is issued.
//
// Ports:
//   Clk             system clock (125 MHz), must be >= 4x camera PCLK
//   i_Rst_n         asynchronous active-low reset
//   i_D             camera data bus
//   i_PLK           camera pixel clock
//   i_VS            camera VSYNC, high = vertical blank
//   i_HS            camera HREF, high = active line bytes
//   i_Arm           single-cycle request to capture the next full frame
//   o_XLK           camera master clock (free running)
//   o_RAM_Data      write data to RAM
//   o_Write_Adress  write address
//   o_Enable_Write  one-cycle write strobe
//   o_Busy          high from accepted arm until done/abort
//   o_Frame_Done    one-cycle pulse after the last byte is written
//   o_Frame_Error   one-cycle pulse when a frame is cut short by VSYNC
// -----------------------------------------------------------------------------
module camera_frame_capture #(
  parameter int FRAME_W     = 96,
  parameter int FRAME_H     = 96,
  parameter int H_OFFSET    = 40,
  parameter int V_OFFSET    = 24,
  parameter int BYTE_SELECT = 1,
  parameter int XLK_DIV     = 5,
  parameter int ADDR_W      = 15
) (
  input  logic              Clk,
  input  logic              i_Rst_n,
  input  logic [7:0]        i_D,
  input  logic              i_PLK,
  input  logic              i_VS,
  input  logic              i_HS,
  input  logic              i_Arm,
  output logic              o_XLK,
  output logic [7:0]        o_RAM_Data,
  output logic [ADDR_W-1:0] o_Write_Adress,
  output logic              o_Enable_Write,
  output logic              o_Busy,
  output logic              o_Frame_Done,
  output logic              o_Frame_Error
);

  localparam int XLK_W = (XLK_DIV > 1) ? $clog2(XLK_DIV) : 1;
  localparam logic [XLK_W-1:0]  XLK_LAST  = XLK_W'(XLK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_W * FRAME_H - 1);
  localparam logic [9:0]        COL_LO    = 10'(H_OFFSET);
  localparam logic [9:0]        COL_HI    = 10'(H_OFFSET + FRAME_W);
  localparam logic [9:0]        LINE_LO   = 10'(V_OFFSET);
  localparam logic [9:0]        LINE_HI   = 10'(V_OFFSET + FRAME_H);
  localparam logic              BYTE_SEL  = 1'(BYTE_SELECT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VS,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Camera master clock: toggles every XLK_DIV cycles regardless of state.
  // ---------------------------------------------------------------------------
  logic [XLK_W-1:0] xlk_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create order-
  // dependent simulation and mismatch the synthesized netlist.
  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      xlk_cnt <= '0;
      o_XLK   <= 1'b0;
    end else if (xlk_cnt == XLK_LAST) begin
      xlk_cnt <= '0;
      o_XLK   <= ~o_XLK;
    end else begin
      xlk_cnt <= xlk_cnt + XLK_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Oversampling synchronizers.  Bit 0 is the first stage; bit 2 is the extra
  // stage used only for edge detection on the control lines.
  // ---------------------------------------------------------------------------
  logic [2:0] plk_sync, vs_sync, hs_sync;
  logic [7:0] d_s1, d_s2;

  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      plk_sync <= '0;
      vs_sync  <= '0;
      hs_sync  <= '0;
      d_s1     <= '0;
      d_s2     <= '0;
    end else begin
      plk_sync <= {plk_sync[1:0], i_PLK};
      vs_sync  <= {vs_sync[1:0], i_VS};
      hs_sync  <= {hs_sync[1:0], i_HS};
      d_s1     <= i_D;
      d_s2     <= d_s1;
    end
  end

  logic plk_rise, vs_rise, vs_fall, hs_rise, hs_fall, byte_evt;

  assign plk_rise = plk_sync[1] & ~plk_sync[2];
  assign vs_rise  = vs_sync[1] & ~vs_sync[2];
  assign vs_fall  = ~vs_sync[1] & vs_sync[2];
  assign hs_rise  = hs_sync[1] & ~hs_sync[2];
  assign hs_fall  = ~hs_sync[1] & hs_sync[2];
  // A camera byte is only meaningful while HREF is high.
  assign byte_evt = plk_rise & hs_sync[1];

  // ---------------------------------------------------------------------------
  // Position counters and keep decision
  // ---------------------------------------------------------------------------
  logic [10:0]       byte_cnt;
  logic [9:0]        line_cnt;
  logic [10:0]       cur_byte;
  logic [9:0]        col;
  logic              keep;
  logic              wr_pend;
  logic [7:0]        wr_byte;
  logic [ADDR_W-1:0] wr_addr;
  logic              last_write;
  logic              abort;

  // A line start coinciding with a byte makes that byte index 0.
  assign cur_byte = hs_rise ? 11'd0 : byte_cnt;
  assign col      = cur_byte[10:1];

  assign keep = byte_evt && (state_q == S_CAPTURE) &&
                (cur_byte[0] == BYTE_SEL) &&
                (col >= COL_LO) && (col < COL_HI) &&
                (line_cnt >= LINE_LO) && (line_cnt < LINE_HI);

  // The final write wins over a VSYNC rise in the same cycle.
  assign last_write = o_Enable_Write && (wr_addr == LAST_ADDR);
  assign abort      = (state_q == S_CAPTURE) && vs_rise && !last_write;

  assign o_Write_Adress = wr_addr;

  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      byte_cnt <= '0;
      line_cnt <= '0;
    end else begin
      if (state_q == S_WAIT_VS && vs_fall) begin
        byte_cnt <= '0;
      end else if (hs_rise) begin
        byte_cnt <= byte_evt ? 11'd1 : 11'd0;
      end else if (byte_evt && byte_cnt != '1) begin
        byte_cnt <= byte_cnt + 11'd1;
      end

      if (state_q == S_WAIT_VS && vs_fall) begin
        line_cnt <= '0;
      end else if (state_q == S_CAPTURE && hs_fall && line_cnt != '1) begin
        line_cnt <= line_cnt + 10'd1;
      end
    end
  end

  // Two-stage write path: the keep decision is registered with its byte, then
  // presented to the RAM as a single-cycle strobe.
  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_pend        <= 1'b0;
      wr_byte        <= '0;
      o_Enable_Write <= 1'b0;
      o_RAM_Data     <= '0;
      o_Frame_Error  <= 1'b0;
      wr_addr        <= '0;
    end else begin
      wr_pend        <= keep;
      wr_byte        <= d_s2;
      o_Enable_Write <= wr_pend && (state_q == S_CAPTURE);
      if (wr_pend) begin
        o_RAM_Data <= wr_byte;
      end
      o_Frame_Error <= abort;

      if (state_q == S_IDLE || state_q == S_DONE || abort || last_write) begin
        wr_addr <= '0;
      end else if (o_Enable_Write) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    o_Busy       = 1'b0;
    o_Frame_Done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_Arm) state_d = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        o_Busy = 1'b1;
        // Waiting for a falling edge skips any frame already in progress.
        if (vs_fall) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        o_Busy = 1'b1;
        if (last_write) state_d = S_DONE;
        else if (vs_rise) state_d = S_IDLE;
      end
      S_DONE: begin
        o_Frame_Done = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_camera_frame_capture.sv
// -----------------------------------------------------------------------------
// Self-checking bench for camera_frame_capture, using a small 4x2 crop.
// A behavioural camera drives lines of bytes valued line*16 + index; the
// expected RAM writes are pushed to a queue as bytes are driven and popped by
// a monitor as the DUT writes them.
// -----------------------------------------------------------------------------
module tb_camera_frame_capture;

  localparam int FW = 4;
  localparam int FH = 2;
  localparam int HO = 1;
  localparam int VO = 1;
  localparam int BS = 1;
  localparam int AW = 15;

  logic          Clk = 1'b0;
  logic          i_Rst_n = 1'b0;
  logic [7:0]    i_D = '0;
  logic          i_PLK = 1'b0;
  logic          i_VS = 1'b0;
  logic          i_HS = 1'b0;
  logic          i_Arm = 1'b0;
  logic          o_XLK;
  logic [7:0]    o_RAM_Data;
  logic [AW-1:0] o_Write_Adress;
  logic          o_Enable_Write;
  logic          o_Busy;
  logic          o_Frame_Done;
  logic          o_Frame_Error;

  camera_frame_capture #(
    .FRAME_W(FW), .FRAME_H(FH), .H_OFFSET(HO), .V_OFFSET(VO),
    .BYTE_SELECT(BS), .XLK_DIV(5), .ADDR_W(AW)
  ) dut (
    .Clk(Clk), .i_Rst_n(i_Rst_n), .i_D(i_D), .i_PLK(i_PLK), .i_VS(i_VS),
    .i_HS(i_HS), .i_Arm(i_Arm), .o_XLK(o_XLK), .o_RAM_Data(o_RAM_Data),
    .o_Write_Adress(o_Write_Adress), .o_Enable_Write(o_Enable_Write),
    .o_Busy(o_Busy), .o_Frame_Done(o_Frame_Done), .o_Frame_Error(o_Frame_Error)
  );

  always #4 Clk = ~Clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] log_q[$];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int exp_addr = 0;
  bit prev_busy = 0;

  // ---------------------------------------------------------------------------
  // Monitor: checks every write against the scoreboard and done/busy timing.
  // ---------------------------------------------------------------------------
  task automatic monitor();
    wr_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (o_Enable_Write) begin
        wr_cnt++;
        log_q.push_back(o_RAM_Data);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected: got addr=%0d data=%02h, no write required",
                   o_Write_Adress, o_RAM_Data);
        end else begin
          e = exp_q.pop_front();
          if (o_Write_Adress !== e.addr || o_RAM_Data !== e.data) begin
            bad++;
            $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                     o_Write_Adress, o_RAM_Data, e.addr, e.data);
          end
        end
      end
      if (o_Frame_Done) begin
        done_cnt++;
        total++;
        if (!(prev_busy == 1'b1 && o_Busy == 1'b0)) begin
          bad++;
          $display("FAIL done_busy: busy before/at done=%0b/%0b, required 1/0",
                   prev_busy, o_Busy);
        end
      end
      if (o_Frame_Error) err_cnt++;
      prev_busy = o_Busy;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Camera model
  // ---------------------------------------------------------------------------
  task automatic model_push(input int line, input int b);
    int c;
    c = b / 2;
    if ((b % 2) == BS && c >= HO && c < HO + FW && line >= VO && line < VO + FH &&
        exp_addr < FW * FH) begin
      exp_q.push_back(wr_t'{addr: AW'(exp_addr), data: 8'(line * 16 + b)});
      exp_addr++;
    end
  endtask

  // One PCLK period of 8 Clk cycles, ending with PLK high.
  task automatic cam_byte(input logic [7:0] d);
    @(negedge Clk);
    i_PLK = 1'b0;
    i_D   = d;
    repeat (3) @(negedge Clk);
    i_PLK = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic line_start();
    @(negedge Clk);
    i_PLK = 1'b0;
    i_HS  = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic line_end();
    @(negedge Clk);
    i_PLK = 1'b0;
    i_HS  = 1'b0;
    repeat (12) @(negedge Clk);
  endtask

  task automatic pulse_arm();
    @(negedge Clk);
    i_Arm = 1'b1;
    @(negedge Clk);
    i_Arm = 1'b0;
  endtask

  // arm_at >= 0 pulses i_Arm just before that byte, while HREF is high.
  task automatic cam_line(input int line, input int nbytes, input bit push, input int arm_at);
    line_start();
    for (int b = 0; b < nbytes; b++) begin
      if (b == arm_at) pulse_arm();
      if (push) model_push(line, b);
      cam_byte(8'(line * 16 + b));
    end
    line_end();
  endtask

  task automatic vs_pulse();
    @(negedge Clk);
    i_VS = 1'b1;
    repeat (24) @(negedge Clk);
    i_VS = 1'b0;
    repeat (24) @(negedge Clk);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 500 && done_cnt == d0; i++) @(posedge Clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [AW+13:0] outs;
    i_Rst_n = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    outs = {o_XLK, o_RAM_Data, o_Write_Adress, o_Enable_Write, o_Busy,
            o_Frame_Done, o_Frame_Error};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    @(negedge Clk);
    i_Rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge Clk);
      #1;
      if (e == 4 || e == 5 || e == 9 || e == 10) begin
        total++;
        if (o_XLK !== ((e == 5 || e == 9) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL xlk_edge%0d: got %b, required %b", e, o_XLK,
                   (e == 5 || e == 9));
        end
      end
    end
    total++;
    if (o_Busy !== 1'b0 || o_Enable_Write !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b we=%b, required 0/0", o_Busy, o_Enable_Write);
    end
  endtask

  task automatic test_capture();
    int d0, w0, e0;
    logic [7:0] golden[8];
    logic [7:0] got;
    golden = '{8'h13, 8'h15, 8'h17, 8'h19, 8'h23, 8'h25, 8'h27, 8'h29};
    d0 = done_cnt; w0 = wr_cnt; e0 = err_cnt;
    log_q.delete();
    exp_addr = 0;
    pulse_arm();
    total++;
    if (o_Busy !== 1'b1) begin
      bad++;
      $display("FAIL capture_busy_after_arm: got %b, required 1", o_Busy);
    end
    vs_pulse();
    for (int l = 0; l < 4; l++) cam_line(l, 16, 1'b1, -1);
    repeat (10) @(negedge Clk);
    total++;
    if (wr_cnt - w0 != 8 || done_cnt - d0 != 1 || err_cnt != e0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL capture_counts: got writes=%0d done=%0d err=%0d left=%0d, required 8/1/0/0",
               wr_cnt - w0, done_cnt - d0, err_cnt - e0, exp_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < log_q.size()) ? log_q[i] : 8'hxx;
      total++;
      if (got !== golden[i]) begin
        bad++;
        $display("FAIL capture_data%0d: got %02h, required %02h", i, got, golden[i]);
      end
    end
    total++;
    if (o_Busy !== 1'b0) begin
      bad++;
      $display("FAIL capture_busy_end: got %b, required 0", o_Busy);
    end
  endtask

  task automatic test_latency();
    int d0;
    d0 = done_cnt;
    exp_addr = 0;
    pulse_arm();
    vs_pulse();
    cam_line(0, 16, 1'b1, -1);
    line_start();
    for (int b = 0; b < 3; b++) begin
      model_push(1, b);
      cam_byte(8'(16 + b));
    end
    model_push(1, 3);
    @(negedge Clk);
    i_PLK = 1'b0;
    i_D   = 8'h13;
    repeat (3) @(negedge Clk);
    i_PLK = 1'b1;
    @(posedge Clk);            // first edge to sample PLK high
    @(posedge Clk);            // 1st
    @(posedge Clk);            // 2nd
    #1;
    total++;
    if (o_Enable_Write !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: got we=%b at edge 2, required 0", o_Enable_Write);
    end
    @(posedge Clk);            // 3rd
    #1;
    total++;
    if (o_Enable_Write !== 1'b1 || o_RAM_Data !== 8'h13) begin
      bad++;
      $display("FAIL latency_edge3: got we=%b data=%02h, required 1/13",
               o_Enable_Write, o_RAM_Data);
    end
    @(posedge Clk);
    #1;
    total++;
    if (o_Enable_Write !== 1'b0) begin
      bad++;
      $display("FAIL latency_width: got we=%b at edge 4, required 0", o_Enable_Write);
    end
    for (int b = 4; b < 16; b++) begin
      model_push(1, b);
      cam_byte(8'(16 + b));
    end
    line_end();
    cam_line(2, 16, 1'b1, -1);
    wait_done(d0);
    total++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL latency_frame: got done=%0d left=%0d, required 1/0",
               done_cnt - d0, exp_q.size());
    end
    cam_line(3, 16, 1'b0, -1);
  endtask

  task automatic test_short_frame();
    int d0, w0, e0;
    d0 = done_cnt; w0 = wr_cnt; e0 = err_cnt;
    exp_addr = 0;
    pulse_arm();
    vs_pulse();
    cam_line(0, 16, 1'b1, -1);
    cam_line(1, 16, 1'b1, -1);
    total++;
    if (wr_cnt - w0 != 4 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL short_writes: got %0d left=%0d, required 4/0", wr_cnt - w0, exp_q.size());
    end
    vs_pulse();
    total++;
    if (err_cnt - e0 != 1 || done_cnt != d0 || o_Busy !== 1'b0) begin
      bad++;
      $display("FAIL short_abort: got err=%0d done=%0d busy=%b, required 1/0/0",
               err_cnt - e0, done_cnt - d0, o_Busy);
    end
    w0 = wr_cnt;
    exp_addr = 0;
    pulse_arm();
    vs_pulse();
    for (int l = 0; l < 3; l++) cam_line(l, 16, 1'b1, -1);
    wait_done(d0);
    total++;
    if (done_cnt - d0 != 1 || wr_cnt - w0 != 8 || exp_q.size() != 0 || err_cnt - e0 != 1) begin
      bad++;
      $display("FAIL short_restart: got done=%0d writes=%0d left=%0d err=%0d, required 1/8/0/1",
               done_cnt - d0, wr_cnt - w0, exp_q.size(), err_cnt - e0);
    end
    cam_line(3, 16, 1'b0, -1);
  endtask

  task automatic test_arm_mid_frame();
    int d0, w0, e0;
    d0 = done_cnt; w0 = wr_cnt; e0 = err_cnt;
    vs_pulse();
    cam_line(0, 16, 1'b0, -1);
    cam_line(1, 16, 1'b0, 5);
    total++;
    if (o_Busy !== 1'b1) begin
      bad++;
      $display("FAIL midarm_busy: got %b, required 1", o_Busy);
    end
    cam_line(2, 16, 1'b0, 3);
    cam_line(3, 16, 1'b0, -1);
    total++;
    if (wr_cnt != w0 || o_Busy !== 1'b1) begin
      bad++;
      $display("FAIL midarm_no_write: got writes=%0d busy=%b, required 0/1", wr_cnt - w0, o_Busy);
    end
    exp_addr = 0;
    vs_pulse();
    for (int l = 0; l < 4; l++) cam_line(l, 16, 1'b1, -1);
    total++;
    if (done_cnt - d0 != 1 || wr_cnt - w0 != 8 || exp_q.size() != 0 || err_cnt != e0) begin
      bad++;
      $display("FAIL midarm_frame: got done=%0d writes=%0d left=%0d err=%0d, required 1/8/0/0",
               done_cnt - d0, wr_cnt - w0, exp_q.size(), err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_capture();
    int d0, w0, e0;
    logic [AW+13:0] outs;
    d0 = done_cnt; w0 = wr_cnt; e0 = err_cnt;
    exp_addr = 0;
    pulse_arm();
    vs_pulse();
    cam_line(0, 16, 1'b1, -1);
    line_start();
    for (int b = 0; b < 8; b++) begin
      model_push(1, b);
      cam_byte(8'(16 + b));
    end
    for (int i = 0; i < 20 && wr_cnt - w0 < 3; i++) @(posedge Clk);
    total++;
    if (wr_cnt - w0 != 3) begin
      bad++;
      $display("FAIL rstmid_writes: got %0d, required 3", wr_cnt - w0);
    end
    @(posedge Clk);
    #3;
    i_Rst_n = 1'b0;
    i_HS    = 1'b0;
    i_PLK   = 1'b0;
    #1;
    outs = {o_XLK, o_RAM_Data, o_Write_Adress, o_Enable_Write, o_Busy,
            o_Frame_Done, o_Frame_Error};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL rstmid_async: got %h, required 0", outs);
    end
    repeat (3) @(negedge Clk);
    exp_q.delete();
    i_Rst_n = 1'b1;
    vs_pulse();
    for (int l = 0; l < 4; l++) cam_line(l, 16, 1'b0, -1);
    total++;
    if (wr_cnt - w0 != 3 || o_Busy !== 1'b0 || done_cnt != d0 || err_cnt != e0) begin
      bad++;
      $display("FAIL rstmid_idle: got writes=%0d busy=%b done=%0d err=%0d, required 3/0/0/0",
               wr_cnt - w0, o_Busy, done_cnt - d0, err_cnt - e0);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_capture();
    test_latency();
    test_short_frame();
    test_arm_mid_frame();
    test_reset_mid_capture();
    repeat (5) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
